// File: rtl/fft_input_loader_if.sv
// Handshake bundle between the serial sample source, the frame loader and
// the first butterfly stage of the 8-point FFT.
interface fft_input_loader_if #(
   parameter int N = 3
);
   localparam int W = 32'd1 << N;

   logic           in_valid;
   logic [W-1:0]   in_data;
   logic           in_sof;
   logic           in_ready;
   logic           frame_valid;
   logic           frame_ready;
   logic [8*W-1:0] frame_data;
   logic           sync_err;

   modport master (
      output in_valid, in_data, in_sof, frame_ready,
      input  in_ready, frame_valid, frame_data, sync_err
   );

   modport slave (
      input  in_valid, in_data, in_sof, frame_ready,
      output in_ready, frame_valid, frame_data, sync_err
   );
endinterface

// File: rtl/fft_input_loader.sv
// Serial-to-parallel front end of the 8-point FFT: fills ping-pong banks in
// bit-reversed slot order and hands complete frames to the butterfly stage.
module fft_input_loader #(
   parameter int N = 3
) (
   input logic               clk,
   input logic               rst,
   fft_input_loader_if.slave bus
);
   localparam int W = 32'd1 << N;

   typedef logic [7:0][W-1:0] frame_t;

   frame_t [1:0] bank_q;
   frame_t [1:0] bank_d;
   logic [2:0]   wr_idx_q;
   logic [2:0]   wr_idx_d;
   logic         wr_bank_q;
   logic         wr_bank_d;
   logic         rd_bank_q;
   logic         rd_bank_d;
   logic [1:0]   full_q;
   logic [1:0]   full_d;
   logic         sync_err_q;
   logic         sync_err_d;
   logic         accept_s;
   logic         release_s;
   logic [2:0]   eidx_s;

   function automatic logic [2:0] bitrev3(input logic [2:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

   assign bus.in_ready    = ~full_q[wr_bank_q];
   assign bus.frame_valid = full_q[rd_bank_q];
   assign bus.frame_data  = bank_q[rd_bank_q];
   assign bus.sync_err    = sync_err_q;

   // Next state: consumer release first, then sample write and frame completion.
   // Completion and release never hit the same bank, so their order is immaterial.
   always_comb begin
      accept_s   = bus.in_valid & ~full_q[wr_bank_q];
      release_s  = full_q[rd_bank_q] & bus.frame_ready;
      eidx_s     = bus.in_sof ? 3'd0 : wr_idx_q;
      bank_d     = bank_q;
      wr_idx_d   = wr_idx_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      full_d     = full_q;
      sync_err_d = 1'b0;

      if (release_s) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end else begin
         rd_bank_d = rd_bank_q;
      end

      if (accept_s) begin
         bank_d[wr_bank_q][bitrev3(eidx_s)] = bus.in_data;
         sync_err_d = bus.in_sof & (wr_idx_q != 3'd0);
         if (eidx_s == 3'd7) begin
            wr_idx_d          = 3'd0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_idx_d = eidx_s + 3'd1;
         end
      end else begin
         sync_err_d = 1'b0;
      end
   end

   // State registers; reset discards every partial and held frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_q     <= '0;
         wr_idx_q   <= 3'd0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         full_q     <= 2'b00;
         sync_err_q <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         wr_idx_q   <= wr_idx_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         sync_err_q <= sync_err_d;
      end
   end
endmodule
